universal_shift_register: RTL

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with clock enable and a synchronous mode select.
- Modes cover hold, parallel load, logical shift left and right with serial input, rotate left and right, and synchronous clear.
- Provides complementary outputs, serial taps and a saturating shift counter with a done flag.
- Serves as the building block for serialiser and deserialiser stages and for scan-style test circuits in the training-data circuit set.

---
 rtl/universal_shift_register.sv | 92 +++++++++
 1 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/clear with clock enable,
// complementary outputs, serial taps and a saturating shift counter.
module universal_shift_register #(
    parameter  int               WIDTH       = 8,
    parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int               CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_CLR   = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             count_step;

    // Shift/rotate are written as whole-vector shifts so WIDTH = 1 needs no special slicing.
    always_comb begin
        q_d        = q_q;
        cnt_d      = cnt_q;
        count_step = 1'b0;
        if (en) begin
            case (mode)
                M_HOLD: ;
                M_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                M_SHL: begin
                    q_d        = (q_q << 1) | WIDTH'(sin);
                    count_step = 1'b1;
                end
                M_SHR: begin
                    q_d        = (q_q >> 1) | (WIDTH'(sin) << (WIDTH - 1));
                    count_step = 1'b1;
                end
                M_ROL: begin
                    q_d        = (q_q << 1) | (q_q >> (WIDTH - 1));
                    count_step = 1'b1;
                end
                M_ROR: begin
                    q_d        = (q_q >> 1) | (q_q << (WIDTH - 1));
                    count_step = 1'b1;
                end
                M_CLR: begin
                    q_d   = RESET_VALUE;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        if (count_step && (cnt_q < CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RESET_VALUE;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q         = q_q;
    assign qbar      = ~q_q;
    assign sout_msb  = q_q[WIDTH-1];
    assign sout_lsb  = q_q[0];
    assign shift_cnt = cnt_q;
    assign done      = (cnt_q == CNT_MAX);

endmodule
